// File: rtl/mask_index_encoder.sv
// rtl/mask_index_encoder.sv - streams the index of every set bit of a mask, lowest first
module mask_index_encoder #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [N-1:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         empty
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [N-1:0] mask_q, mask_d;
  logic         empty_q, empty_d;
  logic [N-1:0] mask_clr;
  logic [W-1:0] low_idx;
  logic         single;

  // Dropping the lowest set bit; a mask whose remainder is zero had exactly one bit left.
  assign mask_clr = mask_q & (mask_q - N'(1));
  assign single   = (mask_q != '0) && (mask_clr == '0);

  assign in_ready  = (state_q == IDLE) && ena;
  assign out_valid = (state_q == EMIT) && ena;
  assign out       = low_idx;
  assign out_last  = out_valid && single;
  assign empty     = empty_q;

  // Priority scan from the top so the lowest set bit wins; zero mask yields index 0.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = W'(i);
    end
  end

  // Next-state: accept a mask in IDLE, peel one bit per output transfer in EMIT.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    empty_d = 1'b0;
    if (in_ready && in_valid) begin
      if (in != '0) begin
        mask_d  = in;
        state_d = EMIT;
      end else begin
        empty_d = 1'b1;
      end
    end
    if (out_valid && out_ready) begin
      mask_d = mask_clr;
      if (single) state_d = IDLE;
    end
  end

  // State registers; ena=0 keeps handshakes low so everything holds except the empty pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: tb/tb_mask_index_encoder.sv
// tb/tb_mask_index_encoder.sv - randomized self-checking bench for mask_index_encoder
module tb_mask_index_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] in;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       empty;

  int n_checks = 0;
  int n_errors = 0;

  mask_index_encoder #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in(in), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: expected index stream is simply the ascending list of set bit positions.
  // mode 0: out_ready always 1; mode 1: pattern 1,0,0,...; mode 2: random ready plus junk in_valid.
  task automatic send_mask(input logic [7:0] m, input int mode, input int freeze_at, input int reset_at);
    int exp_q[$];
    int popped;
    int cyc;
    int frz;
    exp_q = {};
    for (int i = 0; i < 8; i++) if (m[i]) exp_q.push_back(i);
    frz = freeze_at;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    in = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in = 8'($urandom);
    if (m == 8'h00) begin
      @(negedge clk);
      check("empty_pulse", empty, 1);
      check("empty_out_valid", out_valid, 0);
      check("empty_in_ready", in_ready, 1);
      @(negedge clk);
      check("empty_cleared", empty, 0);
      check("empty_out_valid2", out_valid, 0);
      return;
    end
    popped = 0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 64) begin
      @(negedge clk);
      if (popped == frz) begin
        frz = -1;
        ena = 1'b0;
        repeat (3) begin
          #1;
          check("frz_out_valid", out_valid, 0);
          check("frz_in_ready", in_ready, 0);
          check("frz_empty", empty, 0);
          @(negedge clk);
        end
        ena = 1'b1;
        #1;
      end
      if (popped == reset_at) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out", out, 0);
        check("rst_empty", empty, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        return;
      end
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      if (mode == 2) begin
        in_valid = 1'($urandom_range(0, 1));
        in = 8'($urandom);
      end
      check("out_valid", out_valid, 1);
      check("out", out, exp_q[0]);
      check("out_last", out_last, exp_q.size() == 1);
      check("emit_in_ready", in_ready, 0);
      check("emit_empty", empty, 0);
      if (out_ready) begin
        void'(exp_q.pop_front());
        popped++;
      end
      cyc++;
    end
    if (cyc >= 64) check("emit_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("done_out_valid", out_valid, 0);
    check("done_out_last", out_last, 0);
    check("done_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [7:0] m;
    rst_n = 1'b0;
    ena = 1'b1;
    in = 8'h00;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_empty", empty, 0);
    check("reset_out", out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    send_mask(8'hA4, 0, -1, -1);
    send_mask(8'h00, 0, -1, -1);
    send_mask(8'hFF, 1, -1, -1);
    send_mask(8'h80, 0, -1, -1);
    send_mask(8'h01, 0, -1, -1);
    send_mask(8'h18, 0, 1, -1);
    send_mask(8'h0F, 0, -1, 2);
    send_mask(8'h10, 0, -1, -1);

    // A zero mask offered while disabled must not be taken nor pulse empty.
    @(negedge clk);
    ena = 1'b0;
    in = 8'h00;
    in_valid = 1'b1;
    #1;
    check("dis_in_ready", in_ready, 0);
    @(negedge clk);
    check("dis_empty", empty, 0);
    in_valid = 1'b0;
    ena = 1'b1;

    repeat (40) begin
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      send_mask(m, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mask_index_encoder.md
Name: mask_index_encoder

Overview:
- Sequential inverse of the team's 3-to-8 decoder: accepts an N-bit multi-hot mask and emits the index of every set bit, lowest first, one index per handshake.
- Used by the game-of-life lab to turn a row's live-cell mask into a stream of cell indices for downstream update/display logic.
- Valid/ready on both sides.
- `ena` gates all progress, matching the decoder's enable semantics.

Parameters:
- N, 8, mask width; must be ≥2 and a power of two.
- W, $clog2(N) (3), index width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  global enable; 0 freezes all state and handshakes.
- in  input  N  mask to encode.
- in_valid  input  1  `in` is valid.
- in_ready  output  1  block can accept a mask.
- out  output  W  index of the current lowest set bit of the held mask.
- out_valid  output  1  `out` is valid.
- out_ready  input  1  consumer accepts `out`.
- out_last  output  1  `out` is the final index of the current mask.
- empty  output  1  one-cycle pulse: an all-zero mask was accepted.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, held mask=0.
  - in_ready=1, out_valid=0, out_last=0, empty=0, out=0.
- States: IDLE, EMIT.
- Registers:
  - `mask` (N bits).
  - state.
  - `empty` (registered).
- Derived outputs:
  - `out`, `out_last` and `out_valid` are derived combinationally from registered state/mask only.
  - No input-to-output combinational path.
- in_ready = (state==IDLE) && ena.
- out_valid = (state==EMIT) && ena.
- out = index of the lowest set bit of `mask`; 0 when mask==0.
- out_last = out_valid && (mask has exactly one bit set).
- IDLE, when in_valid && in_ready:
  - Nonzero `in`: mask←in; →EMIT; out_valid high on the next cycle (1-cycle latency).
  - Zero `in`: mask unchanged; stay IDLE; empty=1 for exactly the next cycle. No index is emitted.
- EMIT, when out_valid && out_ready:
  - Clear the lowest set bit of `mask`.
  - If out_last: →IDLE, mask becomes 0.
  - Otherwise stay in EMIT; the next index appears the following cycle.
- Throughput:
  - One index per cycle while out_ready=1.
  - Mask of k set bits occupies EMIT for exactly k cycles, plus 1 accept cycle.
  - No new mask is accepted during EMIT (in_ready=0); no overlap or pipelining between masks.
- Backpressure: out_ready=0 holds out, out_last and out_valid stable; the mask is unchanged.
- ena=0:
  - in_ready=0 and out_valid=0; no state or mask change.
  - empty is forced to 0 the cycle after.
  - On re-enable, resume exactly where frozen; the same index is re-presented.
- Boundaries:
  - Mask 0: empty pulse only.
  - Mask all-ones: emits 0..N-1, out_last on N-1.
  - Single bit: one transfer with out_last=1.
  - Bit N-1 alone: out=N-1 (all-ones index, no overflow).
- in_valid asserted in EMIT: ignored; upstream must hold.
- Reset mid-EMIT: immediate return to reset values; the partial mask is discarded and no further indices are emitted.

Test Plan:
- Reset, then in=8'b1010_0100 with in_valid=1 and out_ready=1 → out sequence 2, 5, 7 on three consecutive cycles starting 1 cycle after accept; out_last only with 7; then in_ready=1.
- in=8'b0000_0000 accepted → empty=1 for one cycle; out_valid never asserts; in_ready stays 1.
- in=8'hFF with out_ready toggling 1,0,0,1,... → indices 0..7 in order; none dropped or duplicated; out held stable while out_ready=0; out_last with 7.
- in=8'h80 → single transfer out=7, out_last=1. Then in=8'h01 → out=0, out_last=1.
- in=8'b0001_1000: after index 3 transfers, drop ena for 3 cycles → out_valid=0 and in_ready=0 throughout. On ena=1, out=4 with out_last=1.
- in=8'h0F: assert rst_n=0 after index 1 transfers → outputs return to reset values asynchronously. After release, in_ready=1 and no residual indices appear; a new mask 8'h10 yields only 4.
